aha_clk_div_switch: RTL and testbench

AHA_CLK_DIV_SWITCH -- requirements
Module: aha_clk_div_switch

---
 rtl/aha_clk_div_pkg.sv | 17 +
 rtl/aha_clk_div_pulse_gen.sv | 42 ++++
 rtl/aha_clk_div_switch.sv | 100 ++++++++++
 tb/tb_aha_clk_div_switch.sv | 136 +++++++++++++
 4 files changed

// File: rtl/aha_clk_div_pkg.sv
// Shared types and width helpers for the glitch-free clock-enable divider switch.
package aha_clk_div_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } sw_state_e;

  function automatic int cnt_width(input int n_div);
    return n_div - 1;
  endfunction

  function automatic int sel_width(input int n_div);
    return $clog2(n_div + 1);
  endfunction

endpackage

// File: rtl/aha_clk_div_pulse_gen.sv
// Free-running counter plus registered DIV_EN decode for ratio 2^CUR_SEL.
// An index at or above N_DIV (halt) suppresses DIV_EN while the counter keeps running.
module aha_clk_div_pulse_gen #(
  parameter int N_DIV = 4,
  parameter int CNT_W = 3,
  parameter int SEL_W = 3
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [SEL_W-1:0] CUR_SEL,
  output logic             CNT_MAX,
  output logic             DIV_EN
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_en_q, div_en_d;

  assign cnt_d = cnt_q + CNT_W'(1);

  // Fire when every counter bit below CUR_SEL is set; ratio 1 checks no bits.
  always_comb begin
    div_en_d = 1'b1;
    for (int i = 0; i < CNT_W; i++) begin
      if ((SEL_W'(i) < CUR_SEL) && !cnt_q[i]) div_en_d = 1'b0;
    end
    if (CUR_SEL >= SEL_W'(N_DIV)) div_en_d = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q    <= '0;
      div_en_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      div_en_q <= div_en_d;
    end
  end

  assign CNT_MAX = &cnt_q;
  assign DIV_EN  = div_en_q;

endmodule

// File: rtl/aha_clk_div_switch.sv
// Clock-enable divider whose ratio changes only at the counter wrap, where all ratios align.
// Define AHA_CLK_DIV_SWITCH_HALT_EN to accept SELECT==N_DIV as a halt request.
module aha_clk_div_switch
  import aha_clk_div_pkg::*;
#(
  parameter int  N_DIV = 4,
  localparam int CNT_W = cnt_width(N_DIV),
  localparam int SEL_W = sel_width(N_DIV)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [SEL_W-1:0] SELECT,
  input  logic             SEL_REQ,
  output logic             SEL_BUSY,
  output logic             SEL_ACK,
  output logic             SEL_ERR,
  output logic [SEL_W-1:0] CUR_SEL,
  output logic             DIV_EN,
  output logic             DBG_STATE
);

  sw_state_e        state_q, state_d;
  logic [SEL_W-1:0] pend_sel_q, pend_sel_d;
  logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             cnt_max;
  logic             sel_legal;

`ifdef AHA_CLK_DIV_SWITCH_HALT_EN
  assign sel_legal = (SELECT <= SEL_W'(N_DIV));
`else
  assign sel_legal = (SELECT < SEL_W'(N_DIV));
`endif

  aha_clk_div_pulse_gen #(
    .N_DIV (N_DIV),
    .CNT_W (CNT_W),
    .SEL_W (SEL_W)
  ) u_pulse_gen (
    .CLK     (CLK),
    .RESET   (RESET),
    .CUR_SEL (cur_sel_q),
    .CNT_MAX (cnt_max),
    .DIV_EN  (DIV_EN)
  );

  // Requests are single-cycle strobes; one switch may be outstanding at a time.
  always_comb begin
    state_d    = state_q;
    pend_sel_d = pend_sel_q;
    cur_sel_d  = cur_sel_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (SEL_REQ) begin
          if (sel_legal) begin
            state_d    = ST_PENDING;
            pend_sel_d = SELECT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_PENDING: begin
        if (SEL_REQ) err_d = 1'b1;
        if (cnt_max) begin
          state_d   = ST_IDLE;
          cur_sel_d = pend_sel_q;
          ack_d     = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      pend_sel_q <= '0;
      cur_sel_q  <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_sel_q <= pend_sel_d;
      cur_sel_q  <= cur_sel_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  assign SEL_BUSY  = (state_q == ST_PENDING);
  assign SEL_ACK   = ack_q;
  assign SEL_ERR   = err_q;
  assign CUR_SEL   = cur_sel_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_aha_clk_div_switch.sv
// Directed plus randomized bench for aha_clk_div_switch (N_DIV=4) against a cycle-count model.
module tb_aha_clk_div_switch;

  localparam int N_DIV  = 4;
  localparam int SEL_W  = 3;
  localparam int PERIOD = 1 << (N_DIV - 1);

  logic             CLK = 1'b0;
  logic             RESET = 1'b1;
  logic             SEL_REQ = 1'b0;
  logic [SEL_W-1:0] SELECT = '0;
  logic             SEL_BUSY, SEL_ACK, SEL_ERR, DIV_EN, DBG_STATE;
  logic [SEL_W-1:0] CUR_SEL;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: counter value as time modulo PERIOD, ratio as an integer exponent.
  int m_cnt, m_cur, m_pval;
  bit m_pend, m_div, m_ack, m_err;

  aha_clk_div_switch #(.N_DIV(N_DIV)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .SELECT    (SELECT),
    .SEL_REQ   (SEL_REQ),
    .SEL_BUSY  (SEL_BUSY),
    .SEL_ACK   (SEL_ACK),
    .SEL_ERR   (SEL_ERR),
    .CUR_SEL   (CUR_SEL),
    .DIV_EN    (DIV_EN),
    .DBG_STATE (DBG_STATE)
  );

  always #5 CLK = ~CLK;

  function automatic bit legal(input int s);
`ifdef AHA_CLK_DIV_SWITCH_HALT_EN
    return s <= N_DIV;
`else
    return s < N_DIV;
`endif
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("div_en",   {7'd0, DIV_EN},    {7'd0, m_div});
    check("sel_ack",  {7'd0, SEL_ACK},   {7'd0, m_ack});
    check("sel_err",  {7'd0, SEL_ERR},   {7'd0, m_err});
    check("sel_busy", {7'd0, SEL_BUSY},  {7'd0, m_pend});
    check("dbg_state",{7'd0, DBG_STATE}, {7'd0, m_pend});
    check("cur_sel",  {5'd0, CUR_SEL},   8'(m_cur));
  endtask

  task automatic step(input bit req, input int sel);
    bit bnd, n_pend, n_div, n_ack, n_err;
    int n_cur, n_pval;
    SEL_REQ = req;
    SELECT  = sel[SEL_W-1:0];
    bnd    = (m_cnt == PERIOD - 1);
    n_div  = (m_cur < N_DIV) && (((m_cnt + 1) % (1 << m_cur)) == 0);
    n_ack  = m_pend && bnd;
    n_err  = req && (m_pend || !legal(sel));
    n_cur  = m_cur;
    n_pval = m_pval;
    n_pend = m_pend;
    if (m_pend) begin
      if (bnd) begin
        n_cur  = m_pval;
        n_pend = 1'b0;
      end
    end else if (req && legal(sel)) begin
      n_pend = 1'b1;
      n_pval = sel;
    end
    @(posedge CLK);
    #1;
    m_cnt  = (m_cnt + 1) % PERIOD;
    m_cur  = n_cur;
    m_pval = n_pval;
    m_pend = n_pend;
    m_div  = n_div;
    m_ack  = n_ack;
    m_err  = n_err;
    SEL_REQ = 1'b0;
    check_all();
  endtask

  task automatic do_reset(input int n);
    RESET   = 1'b1;
    SEL_REQ = 1'b0;
    repeat (n) @(posedge CLK);
    #1;
    m_cnt = 0; m_cur = 0; m_pval = 0;
    m_pend = 0; m_div = 0; m_ack = 0; m_err = 0;
    check_all();
    RESET = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 0);
  endtask

  task automatic wait_cnt(input int c);
    for (int i = 0; i < PERIOD && m_cnt != c; i++) step(1'b0, 0);
  endtask

  initial begin
    do_reset(3);
    idle(6);                          // ratio 1: DIV_EN every cycle from release
    wait_cnt(2); step(1'b1, 3); idle(24);
    wait_cnt(7); step(1'b1, 1); idle(12);   // request on the boundary waits a full period
    wait_cnt(1); step(1'b1, 2); idle(2); step(1'b1, 0); idle(12);
    wait_cnt(3); step(1'b1, 5); idle(3);
    step(1'b1, 4); idle(20);          // error, or halt when the halt option is built in
    wait_cnt(5); step(1'b1, 1); idle(20);
    wait_cnt(4); step(1'b1, 1); idle(10);   // same ratio still acknowledged at the boundary
    wait_cnt(2); step(1'b1, 3); idle(2);
    do_reset(2); idle(10);            // reset mid-switch discards the request
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset($urandom_range(1, 3));
      else if ($urandom_range(0, 3) == 0) step(1'b1, $urandom_range(0, 7));
      else step(1'b0, $urandom_range(0, 7));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
